// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_e      : arbiter FSM states (IDLE, WAIT)
//   ARB_IF / ARB_D   : requester ids (fetch, data)
//   DEFAULT_MEM_LAT  : default memory read latency in cycles
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  localparam logic ARB_IF = 1'b0;
  localparam logic ARB_D  = 1'b1;

  localparam int unsigned DEFAULT_MEM_LAT = 1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// the load/store path. One access is outstanding at a time; the response
// (read data or store acknowledge) is returned to the winning requester.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   if_req/if_addr             fetch request and address
//   if_gnt                     fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata         fetch response pulse and registered data
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//   d_gnt                      data accepted this cycle (combinational)
//   d_rvalid/d_rdata           data response pulse; d_rdata is 0 for stores
//   mem_en/mem_we              memory strobe and write enable
//   mem_addr/mem_wdata         memory address/write data, held while idle
//   mem_rdata                  memory read data, valid MEM_LAT cycles after mem_en
//   busy                       an access is outstanding
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LAT      = DEFAULT_MEM_LAT,
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // 3 bits covers the legal latency range 1..4
  localparam int unsigned CNT_W = 3;
  localparam int unsigned RUN_W = $clog2(MAX_DATA_RUN + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [RUN_W-1:0]  run_q;
  logic              win_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic accept;
  logic win;
  logic if_starved;

  // Fetch overrides data only once data has used up its run allowance.
  assign if_starved = if_req && (run_q == RUN_W'(MAX_DATA_RUN));
  assign busy       = (state_q == WAIT);

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    win       = ARB_D;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if ((state_q == IDLE) && !reset && (if_req || d_req)) begin
      accept  = 1'b1;
      win     = (d_req && !if_starved) ? ARB_D : ARB_IF;
      state_d = WAIT;
      mem_en  = 1'b1;
      if (win == ARB_D) begin
        d_gnt     = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else begin
        if_gnt   = 1'b1;
        mem_addr = if_addr;
      end
    end else if ((state_q == WAIT) && (cnt_q == CNT_W'(1))) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      run_q     <= '0;
      win_q     <= ARB_IF;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
    end else begin
      state_q   <= state_d;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (accept) begin
        cnt_q   <= CNT_W'(MEM_LAT);
        win_q   <= win;
        we_q    <= (win == ARB_D) && d_we;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        if (win == ARB_D) begin
          // The run only counts data grants that actually made fetch wait.
          if (!if_req)
            run_q <= '0;
          else if (run_q != RUN_W'(MAX_DATA_RUN))
            run_q <= run_q + RUN_W'(1);
        end else begin
          run_q <= '0;
        end
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (win_q == ARB_D) begin
            d_rvalid <= 1'b1;
            d_rdata  <= we_q ? '0 : mem_rdata;
          end else begin
            if_rvalid <= 1'b1;
            if_rdata  <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned MAXRUN = 4;
  localparam int unsigned NI     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_s     [NI];
  logic          if_req_s    [NI];
  logic [AW-1:0] if_addr_s   [NI];
  logic          if_gnt_s    [NI];
  logic          if_rvalid_s [NI];
  logic [DW-1:0] if_rdata_s  [NI];
  logic          d_req_s     [NI];
  logic          d_we_s      [NI];
  logic [AW-1:0] d_addr_s    [NI];
  logic [DW-1:0] d_wdata_s   [NI];
  logic          d_gnt_s     [NI];
  logic          d_rvalid_s  [NI];
  logic [DW-1:0] d_rdata_s   [NI];
  logic          mem_en_s    [NI];
  logic          mem_we_s    [NI];
  logic [AW-1:0] mem_addr_s  [NI];
  logic [DW-1:0] mem_wdata_s [NI];
  logic [DW-1:0] mem_rdata_s [NI];
  logic          busy_s      [NI];

  function automatic logic [DW-1:0] init_word(input int unsigned i);
    if (i == 1) return 32'h0050_0093;
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  function automatic int unsigned lat_of(input int unsigned g);
    return (g == 0) ? 1 : 3;
  endfunction

  // Instance 0 uses MEM_LAT = 1, instance 1 uses MEM_LAT = 3; each has its
  // own memory whose read data appears exactly MEM_LAT cycles after the strobe.
  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    logic [DW-1:0] mem  [256];
    logic [DW-1:0] pipe [4];
    logic [7:0]    idx;

    mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_DATA_RUN(MAXRUN)
    ) u_dut (
      .clk(clk), .reset(reset_s[g]),
      .if_req(if_req_s[g]), .if_addr(if_addr_s[g]), .if_gnt(if_gnt_s[g]),
      .if_rvalid(if_rvalid_s[g]), .if_rdata(if_rdata_s[g]),
      .d_req(d_req_s[g]), .d_we(d_we_s[g]), .d_addr(d_addr_s[g]),
      .d_wdata(d_wdata_s[g]), .d_gnt(d_gnt_s[g]),
      .d_rvalid(d_rvalid_s[g]), .d_rdata(d_rdata_s[g]),
      .mem_en(mem_en_s[g]), .mem_we(mem_we_s[g]), .mem_addr(mem_addr_s[g]),
      .mem_wdata(mem_wdata_s[g]), .mem_rdata(mem_rdata_s[g]),
      .busy(busy_s[g])
    );

    initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);

    always @(posedge clk) begin
      idx = mem_addr_s[g][9:2];
      // non-strobed cycles push a marker so a mistimed capture is visible
      pipe[0] <= (mem_en_s[g] && !mem_we_s[g]) ? mem[idx] : {24'hBAD000, idx};
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      if (mem_en_s[g] && mem_we_s[g]) mem[idx] = mem_wdata_s[g];
    end

    assign mem_rdata_s[g] = pipe[LAT-1];
  end

  // stimulus staging
  logic          drv_rst [NI];
  logic          drv_ifr [NI];
  logic [AW-1:0] drv_ifa [NI];
  logic          drv_dr  [NI];
  logic          drv_dwe [NI];
  logic [AW-1:0] drv_da  [NI];
  logic [DW-1:0] drv_dwd [NI];

  // transaction-level reference model
  int unsigned   cyc       [NI];
  int unsigned   free_at   [NI];
  int unsigned   run       [NI];
  bit            pend_v    [NI];
  bit            pend_d    [NI];
  int unsigned   pend_due  [NI];
  logic [DW-1:0] pend_data [NI];
  logic [DW-1:0] exp_ifr   [NI];
  logic [DW-1:0] exp_dr    [NI];
  logic [AW-1:0] exp_addr  [NI];
  logic [DW-1:0] exp_wd    [NI];
  logic [DW-1:0] ref_mem   [NI][256];
  bit            last_ifg  [NI];
  bit            last_dg   [NI];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input int unsigned g,
                     input logic [DW-1:0] obs, input logic [DW-1:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s inst%0d cyc%0d: observed %h, expected %h", tag, g, cyc[g], obs, want);
    end
  endtask

  task automatic drive(input int unsigned g, input logic rst,
                       input logic ifr, input logic [AW-1:0] ifa,
                       input logic dr, input logic dwe,
                       input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    drv_rst[g] = rst; drv_ifr[g] = ifr; drv_ifa[g] = ifa;
    drv_dr[g]  = dr;  drv_dwe[g] = dwe; drv_da[g]  = da; drv_dwd[g] = dwd;
  endtask

  task automatic idle(input int unsigned g, input logic rst);
    drive(g, rst, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // One clock cycle: apply staged inputs after the edge, predict, compare at negedge.
  task automatic step(input int unsigned g);
    logic e_ifg, e_dg, e_en, e_we, e_ifv, e_dv, e_busy;
    int unsigned c;
    @(posedge clk);
    #1;
    reset_s[g]  = drv_rst[g];
    if_req_s[g] = drv_ifr[g]; if_addr_s[g] = drv_ifa[g];
    d_req_s[g]  = drv_dr[g];  d_we_s[g]    = drv_dwe[g];
    d_addr_s[g] = drv_da[g];  d_wdata_s[g] = drv_dwd[g];
    @(negedge clk);
    c = cyc[g];
    e_ifg = 0; e_dg = 0; e_en = 0; e_we = 0; e_ifv = 0; e_dv = 0; e_busy = 0;
    if (drv_rst[g]) begin
      pend_v[g] = 0; free_at[g] = 0; run[g] = 0;
      exp_ifr[g] = '0; exp_dr[g] = '0; exp_addr[g] = '0; exp_wd[g] = '0;
    end else begin
      e_busy = (c < free_at[g]);
      if (pend_v[g] && pend_due[g] == c) begin
        pend_v[g] = 0;
        if (pend_d[g]) begin e_dv = 1; exp_dr[g] = pend_data[g]; end
        else begin e_ifv = 1; exp_ifr[g] = pend_data[g]; end
      end
      if (!e_busy && (drv_ifr[g] || drv_dr[g])) begin
        e_en = 1;
        if (drv_dr[g] && !(drv_ifr[g] && run[g] == MAXRUN)) begin
          e_dg = 1;
          e_we = drv_dwe[g];
          exp_addr[g] = drv_da[g];
          if (drv_dwe[g]) begin
            pend_data[g] = '0;
            ref_mem[g][drv_da[g][9:2]] = drv_dwd[g];
            exp_wd[g] = drv_dwd[g];
          end else begin
            pend_data[g] = ref_mem[g][drv_da[g][9:2]];
          end
          run[g] = drv_ifr[g] ? ((run[g] < MAXRUN) ? run[g] + 1 : MAXRUN) : 0;
        end else begin
          e_ifg = 1;
          exp_addr[g] = drv_ifa[g];
          pend_data[g] = ref_mem[g][drv_ifa[g][9:2]];
          run[g] = 0;
        end
        pend_v[g]   = 1;
        pend_d[g]   = e_dg;
        pend_due[g] = c + lat_of(g) + 1;
        free_at[g]  = pend_due[g];
      end
    end
    chk("if_gnt",    g, DW'(if_gnt_s[g]),    DW'(e_ifg));
    chk("d_gnt",     g, DW'(d_gnt_s[g]),     DW'(e_dg));
    chk("mem_en",    g, DW'(mem_en_s[g]),    DW'(e_en));
    chk("mem_we",    g, DW'(mem_we_s[g]),    DW'(e_we));
    chk("mem_addr",  g, mem_addr_s[g],       exp_addr[g]);
    if (e_we || drv_rst[g]) chk("mem_wdata", g, mem_wdata_s[g], exp_wd[g]);
    chk("if_rvalid", g, DW'(if_rvalid_s[g]), DW'(e_ifv));
    chk("d_rvalid",  g, DW'(d_rvalid_s[g]),  DW'(e_dv));
    chk("if_rdata",  g, if_rdata_s[g],       exp_ifr[g]);
    chk("d_rdata",   g, d_rdata_s[g],        exp_dr[g]);
    chk("busy",      g, DW'(busy_s[g]),      DW'(e_busy));
    last_ifg[g] = e_ifg;
    last_dg[g]  = e_dg;
    cyc[g]++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]    order_obs;
    int unsigned   ngr, t0, lat_obs, pulses, last_en;
    bit            have_en, seen, ip, dp;
    logic [AW-1:0] ia, da;
    logic          dwe;
    logic [DW-1:0] dwd;

    for (int unsigned g = 0; g < NI; g++) begin
      reset_s[g] = 1'b1; if_req_s[g] = 1'b0; if_addr_s[g] = '0;
      d_req_s[g] = 1'b0; d_we_s[g] = 1'b0; d_addr_s[g] = '0; d_wdata_s[g] = '0;
      idle(g, 1'b1);
      cyc[g] = 0; free_at[g] = 0; run[g] = 0; pend_v[g] = 0; pend_d[g] = 0;
      pend_due[g] = 0; pend_data[g] = '0; exp_ifr[g] = '0; exp_dr[g] = '0;
      exp_addr[g] = '0; exp_wd[g] = '0; last_ifg[g] = 0; last_dg[g] = 0;
      for (int i = 0; i < 256; i++) ref_mem[g][i] = init_word(i);
    end
    repeat (2) @(posedge clk);

    // ---- fetch only, MEM_LAT = 1 ----
    idle(0, 1'b1); step(0);                       // cycle 0 in reset
    chk("reset_busy", 0, DW'(busy_s[0]), '0);
    chk("reset_if_rdata", 0, if_rdata_s[0], '0);
    idle(0, 1'b0); step(0);                       // cycle 1
    drive(0, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, '0, '0);
    step(0);                                      // cycle 2
    chk("fetch_gnt_c2", 0, DW'(if_gnt_s[0]), 1);
    idle(0, 1'b0); step(0);                       // cycle 3
    chk("fetch_busy_c3", 0, DW'(busy_s[0]), 1);
    step(0);                                      // cycle 4
    chk("fetch_rvalid_c4", 0, DW'(if_rvalid_s[0]), 1);
    chk("fetch_rdata_c4", 0, if_rdata_s[0], 32'h0050_0093);
    chk("fetch_busy_c4", 0, DW'(busy_s[0]), 0);

    // ---- store then load at 0x40 ----
    drive(0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF); step(0);
    chk("store_mem_we", 0, DW'(mem_we_s[0]), 1);
    idle(0, 1'b0); step(0);
    drive(0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h40, '0); step(0);
    chk("store_ack", 0, DW'(d_rvalid_s[0]), 1);
    chk("store_ack_rdata", 0, d_rdata_s[0], '0);
    chk("load_gnt_in_rvalid_cycle", 0, DW'(d_gnt_s[0]), 1);
    idle(0, 1'b0); step(0); step(0);
    chk("load_rdata", 0, d_rdata_s[0], 32'hDEAD_BEEF);

    // ---- request raised during WAIT ----
    drive(0, 1'b0, 1'b1, 32'h8, 1'b0, 1'b0, '0, '0); step(0);   // T
    drive(0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h40, '0); step(0);  // T+1
    chk("no_gnt_in_wait", 0, DW'(d_gnt_s[0]), 0);
    step(0);                                                     // T+2
    chk("gnt_in_rvalid_cycle", 0, DW'(d_gnt_s[0]), 1);
    idle(0, 1'b0); step(0); step(0);

    // ---- simultaneous held requests: D,D,D,D,IF,D,D,D,D,IF ----
    order_obs = '0; ngr = 0; have_en = 0; last_en = 0;
    for (int n = 0; n < 40 && ngr < 10; n++) begin
      drive(0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h44, '0);
      step(0);
      if (mem_en_s[0]) begin
        if (have_en) chk("en_spacing_ok", 0, DW'((cyc[0] - last_en) >= 2), 1);
        have_en = 1; last_en = cyc[0];
      end
      if (if_gnt_s[0] || d_gnt_s[0]) begin
        order_obs = {order_obs[8:0], d_gnt_s[0]};
        ngr++;
      end
    end
    chk("grant_count", 0, ngr, 10);
    chk("grant_order", 0, DW'(order_obs), DW'(10'b1111011110));
    idle(0, 1'b0); step(0); step(0);

    // ---- MEM_LAT = 3 ----
    idle(1, 1'b1); step(1);
    idle(1, 1'b0); step(1);
    drive(1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h20, '0); step(1);
    t0 = cyc[1] - 1; lat_obs = 0; seen = 0;
    idle(1, 1'b0);
    for (int n = 0; n < 8 && !seen; n++) begin
      step(1);
      if (d_rvalid_s[1]) begin seen = 1; lat_obs = cyc[1] - 1 - t0; end
    end
    chk("lat3_rvalid_offset", 1, lat_obs, 4);

    // ---- reset during WAIT ----
    drive(1, 1'b0, 1'b1, 32'h0C, 1'b0, 1'b0, '0, '0); step(1);
    idle(1, 1'b1); step(1);
    chk("rst_wait_busy", 1, DW'(busy_s[1]), 0);
    chk("rst_wait_mem_addr", 1, mem_addr_s[1], '0);
    drive(1, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, '0, '0); step(1);
    chk("post_rst_gnt", 1, DW'(if_gnt_s[1]), 1);
    idle(1, 1'b0); pulses = 0;
    for (int n = 0; n < 6; n++) begin
      step(1);
      if (if_rvalid_s[1]) pulses++;
    end
    chk("post_rst_pulses", 1, pulses, 1);
    chk("post_rst_rdata", 1, if_rdata_s[1], init_word(4));

    // ---- randomized requesters on both instances ----
    for (int unsigned g = 0; g < NI; g++) begin
      ip = 0; dp = 0; ia = '0; da = '0; dwe = 0; dwd = '0;
      for (int n = 0; n < 500; n++) begin
        if (!ip && $urandom_range(0, 2) != 0) begin
          ip = 1; ia = AW'($urandom_range(0, 31)) << 2;
        end
        if (!dp && $urandom_range(0, 2) != 0) begin
          dp = 1; da = AW'($urandom_range(0, 31)) << 2;
          dwe = 1'($urandom_range(0, 1)); dwd = $urandom;
        end
        drive(g, ($urandom_range(0, 127) == 0),
              ip, ip ? ia : AW'($urandom),
              dp, dp ? dwe : 1'($urandom_range(0, 1)),
              dp ? da : AW'($urandom), dp ? dwd : DW'($urandom));
        step(g);
        if (last_ifg[g]) ip = 0;
        if (last_dg[g])  dp = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified memory of the sequential RISC-V processor between the instruction-fetch path and the load/store data path. Each requester uses a request/grant handshake. The arbiter issues one access at a time to the fixed-latency memory and returns read data, or a write acknowledge, to the winning requester. It sits between the processor's fetch/LSU logic and the memory instance, and is the only driver of the memory port.

## Interface
- `ADDR_W`, 32, address width (byte address, passed through unchanged)
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, memory read latency in cycles from `mem_en` to valid `mem_rdata`; legal range 1..4
- `MAX_DATA_RUN`, 4, consecutive data grants allowed while a fetch is pending

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `if_req`  in  1  fetch request valid
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  one-cycle pulse: `if_rdata` valid
- `if_rdata`  out  DATA_W  fetched instruction
- `d_req`  in  1  data request valid
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  one-cycle pulse: load data valid, or store acknowledged
- `d_rdata`  out  DATA_W  load data; 0 on a store acknowledge
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid `MEM_LAT` cycles after `mem_en`
- `busy`  out  1  an access is outstanding (state WAIT)

## Operation
- **States:**
  - IDLE: may accept a request.
  - WAIT: an access is outstanding; a latency counter runs.
- **IDLE with `d_req` or `if_req` high:**
  - Choose a winner. Assert its `gnt`, `mem_en` and (for a store) `mem_we`, all combinationally in the same cycle.
  - Drive `mem_addr`/`mem_wdata` from the winner.
  - Latch the winner id and `d_we`, load the counter with `MEM_LAT`, go to WAIT.
- **Priority:**
  - Data wins over fetch, except when `data_run == MAX_DATA_RUN` and `if_req` is high; then fetch wins.
  - `data_run` increments on each data grant made while `if_req` is high, saturating at `MAX_DATA_RUN`.
  - `data_run` clears on a fetch grant, and on any data grant made while `if_req` is low.
- **WAIT:**
  - The counter decrements each cycle.
  - In the cycle the counter reaches 1, capture `mem_rdata` into the winner's `rdata` register, arm its `rvalid`, and return to IDLE.
- **Handshake rules:**
  - A requester holds `req` and its payload stable until it sees `gnt`.
  - It may drop or change them in the cycle after `gnt`.
  - `req` seen during WAIT is ignored; `gnt` stays low.
- **Outputs when no access is in progress:** `mem_en`, `mem_we` and both `gnt` are 0.
- **Address/data bus:** `mem_addr`/`mem_wdata` hold their last value when idle.

## Timing
- Accept in cycle T (`gnt` = 1, `mem_en` = 1).
- `rvalid` pulses high in cycle T+MAX(`MEM_LAT`,1)+1.
- The next grant can occur in that same `rvalid` cycle, giving a throughput of one access per `MEM_LAT`+1 cycles.
- `rdata` holds its value after the `rvalid` pulse until the next capture for that port.
- **Reset (asynchronous):**
  - State IDLE, counter 0, `data_run` 0.
  - All outputs 0, including `rdata` and `busy`.
- **Reset during WAIT:** the access is abandoned and no `rvalid` is produced. A store already strobed is not retracted.
- **Simultaneous `if_req` and `d_req` with `data_run < MAX_DATA_RUN`:** data is granted and fetch waits, holding `if_req`.

## Structure
- Shared package `mem_arb_pkg`:
  - state typedef (IDLE, WAIT)
  - master-id constants `ARB_IF` = 0, `ARB_D` = 1
  - default `MEM_LAT`
- Single module. Winner selection is a small combinational block inside it; no sub-module.

## Test plan
- **Fetch only, `MEM_LAT` = 1:** `if_req` at cycle 2 with `if_addr` = 0x0000_0004, memory holds 0x0050_0093 → `if_gnt` in cycle 2, `if_rvalid` in cycle 4 with `if_rdata` = 0x0050_0093, `busy` high in cycle 3 only.
- **Store then load, address 0x40:** store `d_wdata` = 0xDEAD_BEEF → `mem_we` = 1 at grant, `d_rvalid` with `d_rdata` = 0. The following load returns 0xDEAD_BEEF.
- **Simultaneous requests, held continuously:** grant order D,D,D,D,IF,D,… (`MAX_DATA_RUN` = 4), with no two `mem_en` closer than 2 cycles.
- **Request during WAIT:** `d_req` raised in cycle T+1 → no `d_gnt` until the `rvalid` cycle of the prior access.
- **`MEM_LAT` = 3:** accept at T → `rvalid` exactly at T+4, and `mem_rdata` sampled at T+3.
- **Reset asserted in WAIT:** all outputs go to 0 immediately with no subsequent `rvalid`. After release, a fresh `if_req` is granted in its first cycle.
